// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access controller: data/address width,
// LC-3 device-register addresses and the controller FSM state encoding.
package mem_pkg;

  localparam int          WIDTH     = 16;

  localparam logic [15:0] DEV_BASE  = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_dev_regs.sv
// LC-3 device registers (KBSR/KBDR/DSR/DDR/MCR) with keyboard and display
// handshakes.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   acc, we, addr,      single-cycle device access strobe from the controller
//   wdata               (store when we=1), address and store data
//   rdata               combinational read of the addressed register (pre-edge value)
//   kbd_valid/kbd_data  keyboard character strobe
//   disp_valid/data     character pending for the display
//   disp_ready          display accepts the pending character
//   mcr_run             MCR[15]
module mem_dev_regs
  import mem_pkg::*;
#(
  parameter int WIDTH = mem_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_data,
  output logic             disp_valid,
  output logic [7:0]       disp_data,
  input  logic             disp_ready,
  output logic             mcr_run
);

  logic             kbsr_rdy;
  logic [7:0]       kbdr;
  logic [WIDTH-1:0] mcr;

  logic ld_kbdr;
  logic st_ddr;
  logic st_mcr;

  // DSR[15] (display idle) is exactly the complement of a pending character.
  assign ld_kbdr = acc && !we && (addr == WIDTH'(KBDR_ADDR));
  assign st_ddr  = acc &&  we && (addr == WIDTH'(DDR_ADDR)) && !disp_valid;
  assign st_mcr  = acc &&  we && (addr == WIDTH'(MCR_ADDR));
  assign mcr_run = mcr[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbsr_rdy   <= 1'b0;
      kbdr       <= 8'h00;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      mcr        <= WIDTH'(16'h8000);
    end else begin
      // A new keystroke wins over the clear caused by reading KBDR.
      if (kbd_valid) begin
        kbdr     <= kbd_data;
        kbsr_rdy <= 1'b1;
      end else if (ld_kbdr) begin
        kbsr_rdy <= 1'b0;
      end

      if (st_ddr) begin
        disp_data  <= wdata[7:0];
        disp_valid <= 1'b1;
      end else if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
      end

      if (st_mcr) mcr <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == WIDTH'(KBSR_ADDR))      rdata = {kbsr_rdy, {(WIDTH-1){1'b0}}};
    else if (addr == WIDTH'(KBDR_ADDR)) rdata = {{(WIDTH-8){1'b0}}, kbdr};
    else if (addr == WIDTH'(DSR_ADDR))  rdata = {!disp_valid, {(WIDTH-1){1'b0}}};
    else if (addr == WIDTH'(MCR_ADDR))  rdata = mcr;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-access controller between the CPU MAR/MDR and the external RAM.
// One load/store at a time: device-page addresses are serviced locally by
// mem_dev_regs, everything else goes to the RAM with a bounded wait on ram_r.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/ready/we/addr/wdata CPU request handshake
//   resp_valid/rdata/err          one-cycle response pulse
//   ram_en/wen/addr/din, ram_dout/ram_r   external RAM interface
//   kbd_*, disp_*, mcr_run        device-register side channels
module mem_ctrl #(
  parameter int                WIDTH    = mem_pkg::WIDTH,
  parameter int                TIMEOUT  = 64,
  parameter logic [WIDTH-1:0]  DEV_BASE = WIDTH'(mem_pkg::DEV_BASE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             ram_en,
  output logic             ram_wen,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic             ram_r,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_data,
  output logic             disp_valid,
  output logic [7:0]       disp_data,
  input  logic             disp_ready,
  output logic             mcr_run
);
  import mem_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             is_dev;
  logic             dev_acc;
  logic [WIDTH-1:0] dev_rdata;

  assign is_dev  = (req_addr >= DEV_BASE);
  assign dev_acc = (state == IDLE) && req_valid && is_dev;

  mem_dev_regs #(.WIDTH(WIDTH)) u_dev (
    .clk        (clk),
    .rst        (rst),
    .acc        (dev_acc),
    .we         (req_we),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .rdata      (dev_rdata),
    .kbd_valid  (kbd_valid),
    .kbd_data   (kbd_data),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .mcr_run    (mcr_run)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_en     <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_we    <= req_we;
            if (is_dev) begin
              // Device access completes on this edge; response next cycle.
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= req_we ? '0 : dev_rdata;
              state      <= RESP;
            end else begin
              ram_en   <= 1'b1;
              ram_wen  <= req_we;
              ram_addr <= req_addr;
              ram_din  <= req_wdata;
              cnt      <= '0;
              state    <= RAM_WAIT;
            end
          end
        end
        RAM_WAIT: begin
          if (ram_r) begin
            ram_en     <= 1'b0;
            ram_wen    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? '0 : ram_dout;
            state      <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            ram_en     <= 1'b0;
            ram_wen    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: stimulus pushes expected responses into a
// queue; a monitor pops and compares each resp_valid pulse.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        ram_en, ram_wen;
  logic [15:0] ram_addr, ram_din;
  logic [15:0] ram_dout = '0;
  logic        ram_r = 1'b0;
  logic        kbd_valid = 1'b0;
  logic [7:0]  kbd_data = '0;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready = 1'b0;
  logic        mcr_run;

  mem_ctrl #(.WIDTH(16), .TIMEOUT(64), .DEV_BASE(16'hFE00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_r(ram_r),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
    .mcr_run(mcr_run)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int req_cyc = 0;
  int last_lat = 0;
  int resp_cnt = 0;

  logic [16:0] exp_q[$];   // {err, rdata}

  // RAM model: ram_r is raised on wait edge number ram_lat (0 = never).
  int          ram_lat = 0;
  logic [15:0] ram_data = '0;
  int          en_cnt = 0;
  int          en_len = 0;
  logic [15:0] last_addr = '0, last_din = '0;
  logic        last_wen = 1'b0;

  logic        kbd_with_req = 1'b0;
  logic [7:0]  kbd_with_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (ram_en) begin
      en_cnt++;
      last_addr = ram_addr;
      last_din  = ram_din;
      last_wen  = ram_wen;
      ram_r     = (ram_lat != 0) && (en_cnt == ram_lat);
      ram_dout  = ram_r ? ram_data : 16'hDEAD;
    end else begin
      if (en_cnt != 0) en_len = en_cnt;
      en_cnt = 0;
      ram_r  = 1'b0;
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (resp_valid) begin
      last_lat = cyc - req_cyc;
      resp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b with nothing outstanding",
                 resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", {16'h0, resp_rdata}, {16'h0, e[15:0]});
        check("resp_err", {31'h0, resp_err}, {31'h0, e[16]});
      end
    end
  end

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err);
    int n0;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL req_ready_wait: got 0 expected 1");
    end
    n0 = resp_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (kbd_with_req) begin
      kbd_valid = 1'b1;
      kbd_data  = kbd_with_data;
    end
    req_cyc = cyc;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    kbd_valid    = 1'b0;
    kbd_with_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (resp_cnt != n0) break;
    end
    if (resp_cnt == n0) begin
      checks++;
      fails++;
      $display("FAIL resp_timeout: got no resp_valid expected one for addr %h", addr);
      void'(exp_q.pop_back());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic kbd_pulse(input logic [7:0] c);
    @(negedge clk);
    kbd_valid = 1'b1;
    kbd_data  = c;
    @(posedge clk);
    #1;
    kbd_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", {16'h0, resp_rdata}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_ram_en", {31'h0, ram_en}, 32'h0);
    check("rst_ram_wen", {31'h0, ram_wen}, 32'h0);
    check("rst_ram_addr", {16'h0, ram_addr}, 32'h0);
    check("rst_ram_din", {16'h0, ram_din}, 32'h0);
    check("rst_disp_valid", {31'h0, disp_valid}, 32'h0);
    check("rst_disp_data", {24'h0, disp_data}, 32'h0);
    check("rst_mcr_run", {31'h0, mcr_run}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // RAM load, ram_r on the 3rd wait edge
    ram_lat = 3; ram_data = 16'hBEEF;
    do_req(1'b0, 16'h3000, 16'h0, 16'hBEEF, 1'b0);
    check("load_en_len", en_len, 3);
    check("load_lat", last_lat, 4);
    check("load_addr", {16'h0, last_addr}, 32'h3000);

    // RAM store, immediate ram_r
    ram_lat = 1; ram_data = 16'h5555;
    do_req(1'b1, 16'h4000, 16'h1234, 16'h0000, 1'b0);
    check("store_lat", last_lat, 2);
    check("store_wen", {31'h0, last_wen}, 32'h1);
    check("store_din", {16'h0, last_din}, 32'h1234);
    check("store_addr", {16'h0, last_addr}, 32'h4000);

    // Keyboard
    kbd_pulse(8'h41);
    do_req(1'b0, 16'hFE00, 16'h0, 16'h8000, 1'b0);
    check("dev_lat", last_lat, 1);
    do_req(1'b0, 16'hFE02, 16'h0, 16'h0041, 1'b0);
    do_req(1'b0, 16'hFE00, 16'h0, 16'h0000, 1'b0);
    // Keystroke coinciding with a KBDR load: old char returned, KBSR stays set
    kbd_pulse(8'h42);
    kbd_with_req = 1'b1; kbd_with_data = 8'h43;
    do_req(1'b0, 16'hFE02, 16'h0, 16'h0042, 1'b0);
    do_req(1'b0, 16'hFE00, 16'h0, 16'h8000, 1'b0);
    do_req(1'b0, 16'hFE02, 16'h0, 16'h0043, 1'b0);

    // Display
    do_req(1'b1, 16'hFE06, 16'h0058, 16'h0000, 1'b0);
    check("disp_valid_set", {31'h0, disp_valid}, 32'h1);
    check("disp_data", {24'h0, disp_data}, 32'h58);
    do_req(1'b0, 16'hFE04, 16'h0, 16'h0000, 1'b0);
    do_req(1'b1, 16'hFE06, 16'h0059, 16'h0000, 1'b0);
    check("disp_drop_busy", {24'h0, disp_data}, 32'h58);
    @(negedge clk);
    disp_ready = 1'b1;
    @(posedge clk);
    #1;
    disp_ready = 1'b0;
    check("disp_valid_clr", {31'h0, disp_valid}, 32'h0);
    do_req(1'b0, 16'hFE04, 16'h0, 16'h8000, 1'b0);

    // Unmapped device address and MCR
    do_req(1'b0, 16'hFE10, 16'h0, 16'h0000, 1'b0);
    do_req(1'b1, 16'hFFFE, 16'h1234, 16'h0000, 1'b0);
    check("mcr_run_clr", {31'h0, mcr_run}, 32'h0);
    do_req(1'b0, 16'hFFFE, 16'h0, 16'h1234, 1'b0);

    // Timeout
    ram_lat = 0;
    do_req(1'b0, 16'h5000, 16'h0, 16'h0000, 1'b1);
    check("timeout_lat", last_lat, 65);
    check("timeout_en_len", en_len, 64);
    check("timeout_en_low", {31'h0, ram_en}, 32'h0);

    // Async reset mid-access: no response must follow
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h6000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_ram_en", {31'h0, ram_en}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("async_ram_en", {31'h0, ram_en}, 32'h0);
    check("async_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_mcr_run", {31'h0, mcr_run}, 32'h1);
    do_req(1'b0, 16'hFFFE, 16'h0, 16'h8000, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-access controller between the CPU datapath's MAR/MDR and the external RAM stage.
- Accepts one CPU load/store request at a time and decodes the address.
- Services LC-3 device registers (KBSR/KBDR/DSR/DDR/MCR) locally; forwards all other addresses to the external RAM.
- Drives the RAM en/wEn/addr/dataIn inputs, waits for its R (ready) output, then returns one response to the CPU. Bounded by a timeout.

Parameters:
- WIDTH, 16, data/address width.
- TIMEOUT, 64, max cycles waiting for ram_r before an error response; must be ≥2.
- DEV_BASE, 16'hFE00, first address of the device-register page.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1=store, 0=load.
- req_addr  in  WIDTH  MAR.
- req_wdata  in  WIDTH  MDR for stores.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  WIDTH  load data; 0 for stores.
- resp_err  out  1  set with resp_valid on timeout.
- ram_en, ram_wen  out  1  RAM enable / write enable.
- ram_addr, ram_din  out  WIDTH  RAM address / write data.
- ram_dout  in  WIDTH  RAM read data.
- ram_r  in  1  RAM ready.
- kbd_valid  in  1  keyboard strobe, one cycle.
- kbd_data  in  8  keyboard character.
- disp_valid  out  1  character pending for display.
- disp_data  out  8  display character.
- disp_ready  in  1  display accepts character.
- mcr_run  out  1  MCR[15]; clock-enable for CPU.

Behaviour:
- Reset values:
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_en=0, ram_wen=0, ram_addr=0, ram_din=0, disp_valid=0, disp_data=0, mcr_run=1.
  - Registers: KBSR=0, KBDR=0, DSR=16'h8000, MCR=16'h8000.
  - FSM: IDLE.
- FSM states: IDLE, RAM_WAIT, RESP.
- IDLE:
  - On req_valid, latch we/addr/wdata.
  - Device address (addr ≥ DEV_BASE): perform the device access this edge and go to RESP.
  - Otherwise: assert ram_en, ram_wen=we, ram_addr, ram_din; clear timeout counter; go to RAM_WAIT.
- RAM_WAIT:
  - ram_en/wen/addr/din held stable.
  - Counter increments each cycle.
  - If ram_r=1 on an edge: capture ram_dout (loads only), drop ram_en/ram_wen, go to RESP.
  - Else if counter reaches TIMEOUT-1: drop ram_en, set err, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with rdata/err.
  - Return to IDLE; req_ready returns high the following cycle.
- Latencies:
  - Device access: request edge to resp_valid = 1 cycle.
  - RAM access: resp_valid in the cycle after ram_r is sampled high.
  - Minimum RAM latency is 2 cycles when ram_r=1 on the first wait edge.
- Device map (addresses not listed read 0 and ignore writes):
  - FE00 KBSR: only bit15 readable; writes ignored.
  - FE02 KBDR: {8'h0, char}; a load clears KBSR[15].
  - FE04 DSR: bit15 = display idle; writes ignored.
  - FE06 DDR: a store while DSR[15]=1 loads disp_data=wdata[7:0], sets disp_valid, clears DSR[15]. A store while DSR[15]=0 is dropped but still responds.
  - FFFE MCR: read/write; mcr_run = MCR[15].
- Keyboard:
  - kbd_valid loads KBDR and sets KBSR[15] in any state. A new character overwrites an unread one.
  - If kbd_valid coincides with a KBDR load: the load returns the old KBDR, and KBSR[15] ends set (set wins over clear).
- Display:
  - When disp_valid & disp_ready on an edge: clear disp_valid and set DSR[15].
  - Independent of the FSM.
- Other rules:
  - req_valid is ignored outside IDLE.
  - Reset mid-access drops ram_en immediately (async); no response is ever issued for the aborted request.

Decomposition:
- Shared package mem_pkg: device address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR, DEV_BASE), FSM state enum, WIDTH.
- One sub-module, mem_dev_regs: KBSR/KBDR/DSR/DDR/MCR storage plus keyboard and display handshakes. The FSM stays in mem_ctrl.

Test Plan:
- RAM load: req addr=16'h3000, ram_r raised on the 3rd wait cycle with ram_dout=16'hBEEF -> ram_en high for exactly 3 cycles, then resp_valid=1, rdata=16'hBEEF, err=0.
- RAM store: addr=16'h4000, wdata=16'h1234, ram_r=1 immediately -> ram_wen=1, ram_din=16'h1234, resp_valid 2 cycles after the request, rdata=0.
- Keyboard: kbd_valid with kbd_data=8'h41.
  - Load FE00 -> rdata=16'h8000.
  - Load FE02 -> rdata=16'h0041.
  - Load FE00 again -> rdata=0.
- Display: store FE06 wdata=16'h0058 -> disp_valid=1, disp_data=8'h58, DSR reads 0. Assert disp_ready -> DSR reads 16'h8000.
- Timeout: TIMEOUT=64, ram_r held 0 -> resp_valid with err=1 on cycle 65 after the request; ram_en low from then on.
- Async reset: assert rst in RAM_WAIT -> ram_en=0 and req_ready=1 without a clock edge; no resp_valid; MCR reads 16'h8000.
